// File: rtl/mc_mem_port_if.sv
// Request/result interface between the control FSM (master) and the
// memory access port (slave).
//
// Handshake: a request is transferred on a rising edge where req_valid
// and req_ready are both high. req_ready is high exactly when the port is
// idle, and the request fields are sampled only on that edge. done is a
// one-cycle registered pulse that follows every completed (non-flushed)
// access. flush cancels an in-flight read and is ignored for writes.
interface mc_mem_port_if #(
    parameter int WORD_SIZE = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic                 req_is_inst;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 flush;
    logic                 done;
    logic [WORD_SIZE-1:0] ir;
    logic [WORD_SIZE-1:0] mdr;
    logic [WORD_SIZE-1:0] num_inst;

    // Control FSM side: issues requests, consumes results
    modport master (
        output req_valid,
        output req_write,
        output req_is_inst,
        output req_addr,
        output req_wdata,
        output flush,
        input  req_ready,
        input  done,
        input  ir,
        input  mdr,
        input  num_inst
    );

    // Memory port side: accepts requests, produces results
    modport slave (
        input  req_valid,
        input  req_write,
        input  req_is_inst,
        input  req_addr,
        input  req_wdata,
        input  flush,
        output req_ready,
        output done,
        output ir,
        output mdr,
        output num_inst
    );
endinterface

// File: rtl/mc_mem_port.sv
// Memory access port for the multi-cycle CPU. Serialises instruction
// fetches and data loads/stores onto the single shared memory bus, holds
// each strobe for MEM_LATENCY cycles, latches read results into IR or MDR
// and counts completed instruction fetches.
module mc_mem_port #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mc_mem_port_if.slave         req,
    output logic                 read_m,
    output logic                 write_m,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 dbg_state_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Counter value on the edge that completes an access
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 inst_q, inst_d;
    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [WORD_SIZE-1:0] mdr_q, mdr_d;
    logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;
    logic                 done_q, done_d;
    logic                 drive_data;

    // State and datapath registers; reset clears everything, including a
    // half-finished access, so no partial write is ever reported done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            inst_q     <= 1'b0;
            ir_q       <= '0;
            mdr_q      <= '0;
            num_inst_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            inst_q     <= inst_d;
            ir_q       <= ir_d;
            mdr_q      <= mdr_d;
            num_inst_q <= num_inst_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: accept in IDLE, count latency in ACCESS, complete
    // or abandon (flushed read) on the final edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        inst_d     = inst_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        num_inst_d = num_inst_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // flush has no meaning here; a request is always taken
                if (req.req_valid) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    addr_d  = req.req_addr;
                    wdata_d = req.req_wdata;
                    write_d = req.req_write;
                    inst_d  = req.req_is_inst;
                end
            end

            ST_ACCESS: begin
                if (!write_q && req.flush) begin
                    // Cancelled read: wins even over the completing edge
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (!write_q) begin
                        if (inst_q) begin
                            ir_d       = data;
                            num_inst_d = num_inst_q + WORD_SIZE'(1);
                        end else begin
                            mdr_d = data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs decode from the registered state only, so an
    // asynchronous reset clears them without waiting for a clock edge.
    always_comb begin
        read_m     = 1'b0;
        write_m    = 1'b0;
        address    = '0;
        drive_data = 1'b0;
        if (state_q == ST_ACCESS) begin
            read_m     = !write_q;
            write_m    = write_q;
            address    = addr_q;
            drive_data = write_q;
        end
    end

    assign data = drive_data ? wdata_q : {WORD_SIZE{1'bz}};

    assign req.req_ready = (state_q == ST_IDLE);
    assign req.done      = done_q;
    assign req.ir        = ir_q;
    assign req.mdr       = mdr_q;
    assign req.num_inst  = num_inst_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mc_mem_port.sv
// Directed bench for mc_mem_port: a MEM_LATENCY=2 instance (a) and a
// MEM_LATENCY=1 instance (b), each with its own small memory model.
module tb_mc_mem_port;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- DUTs and memories ----------------
    mc_mem_port_if #(.WORD_SIZE(16)) bus_a ();
    mc_mem_port_if #(.WORD_SIZE(16)) bus_b ();

    logic        read_m_a, write_m_a, dbg_a;
    logic [15:0] address_a;
    wire  [15:0] data_a;
    logic        read_m_b, write_m_b, dbg_b;
    logic [15:0] address_b;
    wire  [15:0] data_b;

    mc_mem_port #(.WORD_SIZE(16), .MEM_LATENCY(2), .CNT_W(4)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (bus_a),
        .read_m     (read_m_a),
        .write_m    (write_m_a),
        .address    (address_a),
        .data       (data_a),
        .dbg_state_o(dbg_a)
    );

    mc_mem_port #(.WORD_SIZE(16), .MEM_LATENCY(1), .CNT_W(4)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (bus_b),
        .read_m     (read_m_b),
        .write_m    (write_m_b),
        .address    (address_b),
        .data       (data_b),
        .dbg_state_o(dbg_b)
    );

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (write_m_a) mem_a[address_a[7:0]] <= data_a;
        else if (pre_we) mem_a[pre_addr] <= pre_data;
        if (write_m_b) mem_b[address_b[7:0]] <= data_b;
        else if (pre_we) mem_b[pre_addr] <= pre_data;
    end

    assign data_a = read_m_a ? mem_a[address_a[7:0]] : 16'bz;
    assign data_b = read_m_b ? mem_b[address_b[7:0]] : 16'bz;

    // Selected-instance view used by the shared driver tasks
    logic        sel;
    logic        s_read, s_write, s_done, s_ready, s_dbg;
    logic [15:0] s_addr, s_data, s_ir, s_mdr, s_num;
    assign s_read  = sel ? read_m_b        : read_m_a;
    assign s_write = sel ? write_m_b       : write_m_a;
    assign s_done  = sel ? bus_b.done      : bus_a.done;
    assign s_ready = sel ? bus_b.req_ready : bus_a.req_ready;
    assign s_dbg   = sel ? dbg_b           : dbg_a;
    assign s_addr  = sel ? address_b       : address_a;
    assign s_data  = sel ? data_b          : data_a;
    assign s_ir    = sel ? bus_b.ir        : bus_a.ir;
    assign s_mdr   = sel ? bus_b.mdr       : bus_a.mdr;
    assign s_num   = sel ? bus_b.num_inst  : bus_a.num_inst;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic v, input logic w, input logic inst,
                           input logic [15:0] a, input logic [15:0] d, input logic fl);
        if (sel) begin
            bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_is_inst = inst;
            bus_b.req_addr = a;  bus_b.req_wdata = d; bus_b.flush = fl;
        end else begin
            bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_is_inst = inst;
            bus_a.req_addr = a;  bus_a.req_wdata = d; bus_a.flush = fl;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one access and follow it to its done pulse (bounded wait)
    task automatic run_access(input logic w, input logic inst, input logic [15:0] a,
                              input logic [15:0] d, input logic fl_issue,
                              input logic fl_hold, input string tag);
        logic [15:0] strobes;
        logic [15:0] data_hits;
        logic        got_done;
        logic [15:0] lat;
        strobes = 0; data_hits = 0; got_done = 1'b0;
        lat = sel ? 16'd1 : 16'd2;
        set_req(1'b1, w, inst, a, d, fl_issue);
        @(negedge clk);
        set_req(1'b0, w, inst, a, d, fl_hold);
        check({tag, "_addr"}, s_addr, a);
        for (int i = 0; i < 16 && !got_done; i++) begin
            if (s_read || s_write) strobes++;
            if (s_write && s_data == d) data_hits++;
            if (s_done) got_done = 1'b1;
            else @(negedge clk);
        end
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check({tag, "_strobes"}, strobes, lat);
        check({tag, "_done"}, 16'(got_done), 16'd1);
        if (w) check({tag, "_wdata"}, data_hits, lat);
        @(negedge clk);
        check({tag, "_done_once"}, 16'(s_done), 16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rises, dones, cyc, last_rise;
        logic        prev_rd;

        reset_n = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        sel = 1'b1; set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        sel = 1'b0; set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        preload(8'h00, 16'h6001);
        preload(8'h01, 16'h1234);
        preload(8'h02, 16'hAAAA);
        preload(8'h03, 16'h7777);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ready", 16'(s_ready), 16'd1);
        check("rst_state", 16'(s_dbg), 16'd0);
        check("rst_read_m", 16'(s_read), 16'd0);
        check("rst_write_m", 16'(s_write), 16'd0);
        check("rst_addr", s_addr, 16'h0);
        check("rst_ir", s_ir, 16'h0);
        check("rst_mdr", s_mdr, 16'h0);
        check("rst_num", s_num, 16'h0);
        check("rst_done", 16'(s_done), 16'd0);

        // 1: fetch from address 0
        run_access(1'b0, 1'b1, 16'h0000, 16'h0, 1'b0, 1'b0, "fetch0");
        check("fetch0_ir", s_ir, 16'h6001);
        check("fetch0_num", s_num, 16'd1);
        check("fetch0_mdr", s_mdr, 16'h0);

        // 2: store then load
        run_access(1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 1'b0, "store10");
        run_access(1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, "load10");
        check("load10_mdr", s_mdr, 16'hBEEF);
        check("load10_ir", s_ir, 16'h6001);
        check("load10_num", s_num, 16'd1);

        // 3: req_valid held high across four fetches
        set_req(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0, 1'b0);
        rises = 0; dones = 0; cyc = 0; last_rise = 0; prev_rd = s_read;
        for (int i = 0; i < 40 && dones < 4; i++) begin
            @(negedge clk);
            cyc++;
            if (s_read && !prev_rd) begin
                rises++;
                if (rises > 1) check("b2b_interval", cyc - last_rise, 16'd3);
                last_rise = cyc;
                if (rises == 4) set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            end
            if (s_done) dones++;
            prev_rd = s_read;
        end
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("b2b_accepts", rises, 16'd4);
        check("b2b_dones", dones, 16'd4);
        check("b2b_num", s_num, 16'd5);
        check("b2b_ir", s_ir, 16'h1234);
        @(negedge clk);

        // 4a: flush in the cycle after accept
        set_req(1'b1, 1'b0, 1'b1, 16'h0002, 16'h0, 1'b0);
        @(negedge clk);
        check("flush_rd_strobe", 16'(s_read), 16'd1);
        set_req(1'b0, 1'b0, 1'b1, 16'h0002, 16'h0, 1'b1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("flush_rd_idle", 16'(s_ready), 16'd1);
        check("flush_rd_read_m", 16'(s_read), 16'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (s_done) dones++;
            @(negedge clk);
        end
        check("flush_rd_nodone", dones, 16'd0);
        check("flush_rd_ir", s_ir, 16'h1234);
        check("flush_rd_num", s_num, 16'd5);

        // 4b: flush on the completing edge of a read
        set_req(1'b1, 1'b0, 1'b1, 16'h0002, 16'h0, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 16'h0002, 16'h0, 1'b0);
        @(negedge clk);
        check("flush_last_strobe", 16'(s_read), 16'd1);
        set_req(1'b0, 1'b0, 1'b1, 16'h0002, 16'h0, 1'b1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("flush_last_done", 16'(s_done), 16'd0);
        check("flush_last_ir", s_ir, 16'h1234);
        check("flush_last_num", s_num, 16'd5);
        @(negedge clk);

        // 4c: flush in IDLE alongside a request; request still taken
        run_access(1'b0, 1'b1, 16'h0002, 16'h0, 1'b1, 1'b0, "idle_flush");
        check("idle_flush_ir", s_ir, 16'hAAAA);
        check("idle_flush_num", s_num, 16'd6);

        // 4d: flush held through a store; store completes
        run_access(1'b1, 1'b0, 16'h0020, 16'h5555, 1'b0, 1'b1, "flush_store");
        run_access(1'b0, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, "load20");
        check("load20_mdr", s_mdr, 16'h5555);

        // 5: asynchronous reset in the middle of a read
        set_req(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("midrst_pre_read", 16'(s_read), 16'd1);
        check("midrst_pre_addr", s_addr, 16'h0003);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_read_m", 16'(s_read), 16'd0);
        check("midrst_addr", s_addr, 16'h0);
        check("midrst_ir", s_ir, 16'h0);
        check("midrst_mdr", s_mdr, 16'h0);
        check("midrst_num", s_num, 16'h0);
        check("midrst_state", 16'(s_dbg), 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_access(1'b0, 1'b1, 16'h0000, 16'h0, 1'b0, 1'b0, "post_rst");
        check("post_rst_ir", s_ir, 16'h6001);
        check("post_rst_num", s_num, 16'd1);

        // 6: num_inst wraps past 0xFFFF
        force dut_a.num_inst_q = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release dut_a.num_inst_q;
        @(negedge clk);
        check("wrap_pre_num", s_num, 16'hFFFF);
        run_access(1'b0, 1'b1, 16'h0003, 16'h0, 1'b0, 1'b0, "wrap");
        check("wrap_num", s_num, 16'h0000);
        check("wrap_ir", s_ir, 16'h7777);

        // 6: MEM_LATENCY = 1 instance
        sel = 1'b1;
        @(negedge clk);
        check("lat1_ready", 16'(s_ready), 16'd1);
        run_access(1'b0, 1'b1, 16'h0000, 16'h0, 1'b0, 1'b0, "lat1_fetch");
        check("lat1_ir", s_ir, 16'h6001);
        check("lat1_num", s_num, 16'd1);
        run_access(1'b1, 1'b0, 16'h0030, 16'hC0DE, 1'b0, 1'b0, "lat1_store");
        run_access(1'b0, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, "lat1_load");
        check("lat1_mdr", s_mdr, 16'hC0DE);
        check("lat1_ir_hold", s_ir, 16'h6001);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
